aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
- Sequential AES key schedule (FIPS-197 KeyExpansion) generalised over the three key lengths, selected by parameters NK/NR.
- Accepts one cipher key through a valid/ready handshake, then streams the NB*(NR+1) round-key words w[0..] one per handshake, word index attached.
- Sits between the key source and the round datapath inside top; the datapath consumes words in order, NB words per round.

Parameters:
- WORD, 32, word size in bits; only 32 is supported.
- NB, 4, number of data words per round key.
- NK, 4, key length in words: 4, 6 or 8. Any other value is rejected at elaboration ($error).
- NR, 10, number of rounds. Must equal NK+6, checked at elaboration.
- TOTAL, NB*(NR+1), local: total words emitted (44 / 52 / 60).
- IW, $clog2(TOTAL), local: index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  key_in is valid
- key_ready  out  1  block accepts a new key
- key_in  in  NK*WORD  cipher key; w[0] = key_in[NK*WORD-1 -: WORD] (MSW first)
- rk_valid  out  1  rk_word/rk_index/rk_last are valid
- rk_ready  in  1  consumer accepts the current word
- rk_word  out  WORD  round-key word w[rk_index]
- rk_index  out  IW  index i of the current word, 0..TOTAL-1
- rk_last  out  1  high with the final word, i = TOTAL-1
- busy  out  1  high from key accept until the last word is accepted

Behaviour:
- Reset values: key_ready=1, rk_valid=0, rk_word=0, rk_index=0, rk_last=0, busy=0; state IDLE; Rcon=0x01; key window cleared.
- States: IDLE -> EMIT -> IDLE.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid&&key_ready: load the NK-word window from key_in, set rk_word=w[0], rk_index=0, rk_valid=1, busy=1, Rcon=0x01, go to EMIT.
  - Latency from key accept to first rk_valid is 1 cycle.
- EMIT:
  - key_ready=0; key_valid is ignored.
  - On rk_valid&&rk_ready: if rk_index==TOTAL-1, go to IDLE with rk_valid=0, busy=0. Otherwise register w[i+1] into rk_word, increment rk_index, and shift the window.
  - Throughput is 1 word/cycle while rk_ready stays high.
- Stability: while rk_valid&&!rk_ready, rk_word, rk_index and rk_last hold stable. rk_valid never drops without a handshake.
- Word generation, for i = rk_index+1:
  - i < NK: w[i] is key word i.
  - i >= NK: temp = w[i-1].
    - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}, then Rcon <= xtime(Rcon), where xtime = shift left 1 and XOR 0x1B on carry-out of bit 7.
    - Else if NK==8 and i mod NK == 4: temp = SubWord(temp).
    - w[i] = w[i-NK] ^ temp.
- Implementation rules:
  - RotWord rotates bytes left by one.
  - SubWord applies the AES S-box to each of the 4 bytes; one shared 4-byte S-box instance, combinational.
  - Window is an NK-deep shift register of the most recent words. The i mod NK counter wraps at NK, no divider.
- rk_last = rk_valid && rk_index==TOTAL-1, registered with rk_word.
- Back-to-back keys: after the last handshake, the block is in IDLE with key_ready=1 on the next cycle. No key is accepted in the cycle the last word completes.
- rst mid-EMIT: on the next edge all outputs return to reset values. The partial schedule is discarded; the consumer sees no rk_last.
- Output must equal the FIPS-197 key expansion for every NK; no other behaviour is permitted.

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> w[0]=2b7e1516, w[4]=a0fafe17, w[43]=b6630ca6 with rk_last=1; 44 words on consecutive cycles, first word 1 cycle after accept.
- NK=6/NR=12, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202; 52 words.
- NK=8/NR=14, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[8]=9ba35411, w[59]=706c631e; checks the i mod 8 == 4 SubWord path and 60 words.
- NK=4 key with random rk_ready stalls (~50%) -> word/index held stable during every stall; sequence identical to the no-stall run; busy falls the cycle after the last handshake.
- key_valid held high through EMIT with a second key -> second key is not accepted until IDLE; the first schedule is uncorrupted; the second key is accepted the cycle after rk_last completes and produces its own correct w[0].
- rst asserted at rk_index=20 -> next cycle rk_valid=0, key_ready=1, busy=0; a new key then expands correctly from w[0] with Rcon restarted at 0x01 (w[4] matches the reference).

Source files
------------

// File: rtl/aes_key_expand.sv
// AES key schedule: accepts one cipher key, then streams round-key words w[0..TOTAL-1] in order.
// Latency: first word 1 cycle after key accept, then 1 word/cycle; outputs hold while rk_ready is low.
module aes_key_expand #(
    parameter int WORD = 32,
    parameter int NB   = 4,
    parameter int NK   = 4,
    parameter int NR   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [NK*WORD-1:0]     key_in,
    output logic                   rk_valid,
    input  logic                   rk_ready,
    output logic [WORD-1:0]        rk_word,
    output logic [$clog2(NB*(NR+1))-1:0] rk_index,
    output logic                   rk_last,
    output logic                   busy
);
    localparam int TOTAL = NB * (NR + 1);
    localparam int IW    = $clog2(TOTAL);
    localparam int MW    = $clog2(NK);
    localparam logic [MW-1:0] MOD_SUB = MW'(4);

    generate
        if (WORD != 32) begin : g_bad_word
            $error("aes_key_expand: WORD must be 32");
        end
        if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
            $error("aes_key_expand: NK must be 4, 6 or 8");
        end
        if (NR != NK + 6) begin : g_bad_nr
            $error("aes_key_expand: NR must equal NK+6");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254, with 0 mapping to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t          state_q;
    logic [WORD-1:0] win_q [NK];
    logic [MW-1:0]   mod_q;
    logic [7:0]      rcon_q;
    logic            key_ready_q, rk_valid_q, rk_last_q, busy_q;
    logic [WORD-1:0] rk_word_q;
    logic [IW-1:0]   rk_index_q;

    logic [IW-1:0]   next_idx;
    logic [MW-1:0]   mod_d;
    logic            gen_phase;
    logic [31:0]     sub_in, sub_out, temp, key_word, next_word_d;

    assign next_idx  = rk_index_q + IW'(1);
    assign mod_d     = (mod_q == MW'(NK - 1)) ? '0 : mod_q + MW'(1);
    assign gen_phase = rk_index_q >= IW'(NK - 1);

    // mod_q tracks (rk_index+1) mod NK, the index of the word being prepared.
    always_comb begin
        sub_in  = (mod_q == '0) ? {rk_word_q[23:0], rk_word_q[31:24]} : rk_word_q;
        sub_out = sub_word(sub_in);
        temp    = rk_word_q;
        if (mod_q == '0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && mod_q == MOD_SUB) begin
            temp = sub_out;
        end
        key_word = '0;
        for (int k = 0; k < NK; k++) begin
            if (next_idx == IW'(k)) key_word = win_q[k];
        end
        next_word_d = gen_phase ? (win_q[0] ^ temp) : key_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            rk_word_q   <= '0;
            rk_index_q  <= '0;
            rk_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            rcon_q      <= 8'h01;
            mod_q       <= '0;
            for (int k = 0; k < NK; k++) win_q[k] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_valid && key_ready_q) begin
                        for (int k = 0; k < NK; k++) win_q[k] <= key_in[(NK-k)*WORD-1 -: WORD];
                        rk_word_q   <= key_in[NK*WORD-1 -: WORD];
                        rk_index_q  <= '0;
                        rk_last_q   <= 1'b0;
                        rk_valid_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        key_ready_q <= 1'b0;
                        rcon_q      <= 8'h01;
                        mod_q       <= MW'(1);
                        state_q     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (rk_ready) begin
                        if (rk_last_q) begin
                            rk_valid_q  <= 1'b0;
                            rk_last_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            key_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            rk_word_q  <= next_word_d;
                            rk_index_q <= next_idx;
                            rk_last_q  <= (next_idx == IW'(TOTAL - 1));
                            mod_q      <= mod_d;
                            if (gen_phase) begin
                                for (int k = 0; k < NK - 1; k++) win_q[k] <= win_q[k+1];
                                win_q[NK-1] <= next_word_d;
                                if (mod_q == '0) rcon_q <= xtime(rcon_q);
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign key_ready = key_ready_q;
    assign rk_valid  = rk_valid_q;
    assign rk_word   = rk_word_q;
    assign rk_index  = rk_index_q;
    assign rk_last   = rk_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: three instances (NK=4/6/8) checked against FIPS vectors and a reference model.
module tb_aes_key_expand;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        kv [3];
    logic        ky [3];
    logic        rv [3];
    logic        rr [3];
    logic [31:0] rw [3];
    logic [5:0]  ri [3];
    logic        rl [3];
    logic        bz [3];
    logic [127:0] k4;
    logic [191:0] k6;
    logic [255:0] k8;

    aes_key_expand #(.WORD(32), .NB(4), .NK(4), .NR(10)) dut4 (
        .clk(clk), .rst(rst), .key_valid(kv[0]), .key_ready(ky[0]), .key_in(k4),
        .rk_valid(rv[0]), .rk_ready(rr[0]), .rk_word(rw[0]), .rk_index(ri[0]),
        .rk_last(rl[0]), .busy(bz[0]));
    aes_key_expand #(.WORD(32), .NB(4), .NK(6), .NR(12)) dut6 (
        .clk(clk), .rst(rst), .key_valid(kv[1]), .key_ready(ky[1]), .key_in(k6),
        .rk_valid(rv[1]), .rk_ready(rr[1]), .rk_word(rw[1]), .rk_index(ri[1]),
        .rk_last(rl[1]), .busy(bz[1]));
    aes_key_expand #(.WORD(32), .NB(4), .NK(8), .NR(14)) dut8 (
        .clk(clk), .rst(rst), .key_valid(kv[2]), .key_ready(ky[2]), .key_in(k8),
        .rk_valid(rv[2]), .rk_ready(rr[2]), .rk_word(rw[2]), .rk_index(ri[2]),
        .rk_last(rl[2]), .busy(bz[2]));

    int checks = 0;
    int errors = 0;
    logic [7:0]  sbox_tab [256];
    logic [31:0] model_w [60];
    logic [31:0] got [3][60];

    typedef struct {
        int           d;
        logic [255:0] key;
        int           idx;
        logic [31:0]  exp;
    } vec_t;
    vec_t vecs [7];

    function automatic int nk_of(input int d);
        return 4 + 2 * d;
    endfunction

    function automatic int tot_of(input int d);
        return 4 * (nk_of(d) + 7);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11b;
        end
        return p;
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv, c, s;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[a] = s;
        end
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic void expand(input int nk, input logic [255:0] key);
        logic [31:0] t;
        logic [7:0]  rcon;
        int          total;
        total = 4 * (nk + 7);
        rcon  = 8'h01;
        for (int i = 0; i < nk; i++) model_w[i] = key[nk*32-1-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = model_w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            model_w[i] = model_w[i-nk] ^ t;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_key(input int d, input logic [255:0] key);
        case (d)
            0: k4 = key[127:0];
            1: k6 = key[191:0];
            default: k8 = key;
        endcase
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic start_key(input int d, input logic [255:0] key, input bit hold);
        chk("key_ready_idle", 64'(ky[d]), 64'd1);
        set_key(d, key);
        kv[d] = 1'b1;
        @(negedge clk);
        if (!hold) kv[d] = 1'b0;
    endtask

    task automatic recv(input int d, input logic [255:0] key, input bit stall, input int abort_at);
        int n = 0;
        int cyc = 0;
        bit pstall = 0;
        logic [31:0] pw = '0;
        logic [5:0]  pi = '0;
        expand(nk_of(d), key);
        chk("first_valid", 64'(rv[d]), 64'd1);
        chk("first_index", 64'(ri[d]), 64'd0);
        while (n < tot_of(d) && cyc < 4000) begin
            if (pstall) begin
                chk("stall_word", 64'(rw[d]), 64'(pw));
                chk("stall_index", 64'(ri[d]), 64'(pi));
            end
            if (abort_at >= 0 && n == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_valid", 64'(rv[d]), 64'd0);
                chk("abort_key_ready", 64'(ky[d]), 64'd1);
                chk("abort_busy", 64'(bz[d]), 64'd0);
                chk("abort_last", 64'(rl[d]), 64'd0);
                chk("abort_word", 64'(rw[d]), 64'd0);
                chk("abort_index", 64'(ri[d]), 64'd0);
                return;
            end
            chk("valid_held", 64'(rv[d]), 64'd1);
            chk("busy_emit", 64'(bz[d]), 64'd1);
            chk("key_ready_emit", 64'(ky[d]), 64'd0);
            rr[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rv[d] && rr[d]) begin
                chk("index", 64'(ri[d]), 64'(n));
                chk("word", 64'(rw[d]), 64'(model_w[n]));
                chk("last", 64'(rl[d]), 64'(n == tot_of(d) - 1));
                got[d][n] = rw[d];
                n++;
                pstall = 0;
            end else begin
                pstall = rv[d];
                pw = rw[d];
                pi = ri[d];
            end
            cyc++;
            @(negedge clk);
        end
        rr[d] = 1'b1;
        if (n < tot_of(d)) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d words expected %0d", n, tot_of(d));
        end
        if (!stall) chk("cycles", 64'(cyc), 64'(tot_of(d)));
        chk("done_valid", 64'(rv[d]), 64'd0);
        chk("done_busy", 64'(bz[d]), 64'd0);
        chk("done_key_ready", 64'(ky[d]), 64'd1);
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] ka, kb;
        rst = 1'b1;
        k4 = '0; k6 = '0; k8 = '0;
        for (int d = 0; d < 3; d++) begin
            kv[d] = 1'b0;
            rr[d] = 1'b1;
        end
        build_sbox();

        vecs[0] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 0, 32'h2b7e1516};
        vecs[1] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 4, 32'ha0fafe17};
        vecs[2] = '{0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 43, 32'hb6630ca6};
        vecs[3] = '{1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 6, 32'hfe0c91f7};
        vecs[4] = '{1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 51, 32'h01002202};
        vecs[5] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 8, 32'h9ba35411};
        vecs[6] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 59, 32'h706c631e};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_key_ready", 64'(ky[d]), 64'd1);
            chk("rst_valid", 64'(rv[d]), 64'd0);
            chk("rst_word", 64'(rw[d]), 64'd0);
            chk("rst_index", 64'(ri[d]), 64'd0);
            chk("rst_last", 64'(rl[d]), 64'd0);
            chk("rst_busy", 64'(bz[d]), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Known-answer vectors, full-rate consumer.
        for (int v = 0; v < 7; v++) begin
            start_key(vecs[v].d, vecs[v].key, 1'b0);
            recv(vecs[v].d, vecs[v].key, 1'b0, -1);
            chk("fips_vector", 64'(got[vecs[v].d][vecs[v].idx]), 64'(vecs[v].exp));
        end

        // Stalled consumer on the FIPS NK=4 key, then random keys on every width.
        start_key(0, vecs[0].key, 1'b0);
        recv(0, vecs[0].key, 1'b1, -1);
        chk("stall_w43", 64'(got[0][43]), 64'h00000000b6630ca6);
        for (int r = 0; r < 3; r++) begin
            for (int d = 0; d < 3; d++) begin
                ka = rand_key();
                start_key(d, ka, 1'b0);
                recv(d, ka, 1'(r != 0), -1);
            end
        end

        // Second key held on key_valid throughout the first schedule.
        ka = rand_key();
        kb = rand_key();
        start_key(0, ka, 1'b1);
        set_key(0, kb);
        recv(0, ka, 1'b1, -1);
        @(negedge clk);
        kv[0] = 1'b0;
        recv(0, kb, 1'b0, -1);

        // Reset in the middle of a schedule, then a clean restart.
        ka = rand_key();
        start_key(0, ka, 1'b0);
        recv(0, ka, 1'b0, 20);
        start_key(0, vecs[0].key, 1'b0);
        recv(0, vecs[0].key, 1'b0, -1);
        chk("restart_w4", 64'(got[0][4]), 64'h00000000a0fafe17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
